fifo_up_buffer: RTL
===================

# fifo_up_buffer

Synchronous single-clock FIFO that sits directly downstream of the 1x2 demux, one instance per demux output lane. It stores 10-bit packet words pushed by the demux, returns them in order to the downstream consumer, and reports `almost_full` back to the demux so that pushes stop before data is lost. Overflow and underflow attempts are blocked and recorded in a sticky error flag.

## Interface
- `DATA_SIZE`, 10, word width
- `ADDR_SIZE`, 3, pointer width; depth = 2^ADDR_SIZE = 8
- `AF_THRESHOLD`, 6, `almost_full` asserts when occupancy >= this value
- `AE_THRESHOLD`, 1, `almost_empty` asserts when occupancy <= this value
- `clk`  in  1  rising-edge clock; the only clock
- `reset`  in  1  synchronous, active-high reset
- `push`  in  1  write request, driven by the demux `push_N`
- `data_in`  in  DATA_SIZE  write word, driven by the demux `outN`
- `pop`  in  1  read request from the consumer
- `data_out`  out  DATA_SIZE  registered read word
- `valid_out`  out  1  `data_out` holds a word popped on the previous edge
- `full`  out  1  occupancy == depth
- `empty`  out  1  occupancy == 0
- `almost_full`  out  1  occupancy >= AF_THRESHOLD; feeds the demux `fifo_upN_almostfull`
- `almost_empty`  out  1  occupancy <= AE_THRESHOLD
- `count`  out  ADDR_SIZE+1  current occupancy, 0..depth
- `error`  out  1  sticky overflow/underflow indicator

## Operation
- Storage: a register array of depth x DATA_SIZE, with write pointer `wr_ptr` and read pointer `rd_ptr` (ADDR_SIZE bits each). Both pointers wrap modulo depth (7 -> 0). `count` is a separate ADDR_SIZE+1 register.
- Reset (`reset`=1 at a rising edge): `wr_ptr`=0, `rd_ptr`=0, `count`=0, `data_out`=0, `valid_out`=0, `error`=0. Memory contents are not cleared. Resulting flags: `empty`=1, `almost_empty`=1, `full`=0, `almost_full`=0. Reset overrides `push` and `pop` on the same edge. Reset asserted mid-stream discards all stored words.
- Accepted push: `push`=1 and (not `full`, or `pop` accepted on the same edge). The FIFO writes `data_in` to `mem[wr_ptr]` and increments `wr_ptr`.
- Accepted pop: `pop`=1 and not `empty`. The FIFO loads `data_out` <= `mem[rd_ptr]`, increments `rd_ptr`, and sets `valid_out`=1.
- Any edge without an accepted pop: `valid_out`=0. `data_out` holds its last value.
- `count` update: +1 on a push-only edge, -1 on a pop-only edge, unchanged when both or neither are accepted.
- Full with push and pop together: both are accepted, and `count` stays at depth.
- Empty with push and pop together: the push is accepted and the pop is rejected, so `count` becomes 1. No bypass: the word is not forwarded on the same edge.
- Overflow: `push`=1, `full`=1, no accepted pop. The word is dropped, pointers are unchanged, and `error` <= 1.
- Underflow: `pop`=1, `empty`=1. No read occurs, `valid_out`=0, and `error` <= 1.
- `error` stays at 1 until reset.
- Flags are combinational decodes of the registered `count` only; no input feeds a flag directly.

## Timing
- Write-to-visible latency is 1 edge: a push at edge N raises `count` and clears `empty` after edge N.
- Read latency is 1 edge: a pop sampled at edge N presents `data_out`/`valid_out` after edge N, valid for one cycle per pop.
- Back-to-back pops at the full rate of 1 word per cycle are supported. Throughput is 1 push plus 1 pop per cycle.
- `almost_full` rises after the edge that brings `count` to 6. This leaves 2 free slots to absorb the demux's registered push pipeline (up to 1 in-flight word) without overflow.
- All outputs change only on the rising edge of `clk`.

## Test plan
- Reset: hold `reset`=1 for 3 edges while `push`=1 and `pop`=1 -> `count`=0, `empty`=1, `valid_out`=0, `data_out`=0x000, `error`=0.
- Ordering: push 0x0FF, 0x0EE, 0x0BB, 0x0AA on consecutive edges, then pop 4 times -> `data_out` = 0x0FF, 0x0EE, 0x0BB, 0x0AA on consecutive cycles with `valid_out`=1. After that, `empty`=1.
- Thresholds and full: push 8 words (0x101..0x108) -> `almost_full` rises after the 6th push, `full`=1 and `count`=8 after the 8th. A 9th push of 0x1FF -> `error`=1, `count`=8, and the pops return 0x101..0x108 only.
- Simultaneous at full: with 8 stored, assert push 0x177 + pop together -> `data_out`=oldest word, `count`=8, `error`=0. Draining returns 0x177 last.
- Underflow and wrap: pop while empty -> `valid_out`=0, `error`=1. Then run 20 push/pop pairs of 0x1A7+i with `count` hovering at 1 -> every word returned in order across the pointer wrap at 7 -> 0.
- Reset mid-stream: with 5 words stored, pulse `reset` for 1 edge -> `count`=0, `empty`=1. A new push of 0x1CC followed by a pop returns 0x1CC.

Source files
------------

// File: rtl/fifo_up_buffer_if.sv
// Handshake and status bundle between a demux lane, its FIFO and the consumer.
interface fifo_up_buffer_if #(
    parameter int unsigned DATA_SIZE = 10,
    parameter int unsigned ADDR_SIZE = 3
);
    logic                   push;
    logic [DATA_SIZE-1:0]   data_in;
    logic                   pop;
    logic [DATA_SIZE-1:0]   data_out;
    logic                   valid_out;
    logic                   full;
    logic                   empty;
    logic                   almost_full;
    logic                   almost_empty;
    logic [ADDR_SIZE:0]     count;
    logic                   error;

    // Producer/consumer side: issues requests, observes data and status.
    modport master (
        output push, data_in, pop,
        input  data_out, valid_out, full, empty,
        input  almost_full, almost_empty, count, error
    );

    // FIFO side: accepts requests, returns data and status.
    modport slave (
        input  push, data_in, pop,
        output data_out, valid_out, full, empty,
        output almost_full, almost_empty, count, error
    );
endinterface

// File: rtl/fifo_up_buffer.sv
// Single-clock FIFO placed after each demux output lane. Stores words in
// order, raises almost_full early enough to absorb the demux push pipeline,
// and records any blocked overflow/underflow attempt in a sticky error flag.
module fifo_up_buffer #(
    parameter int unsigned DATA_SIZE    = 10,
    parameter int unsigned ADDR_SIZE    = 3,
    parameter int unsigned AF_THRESHOLD = 6,
    parameter int unsigned AE_THRESHOLD = 1
) (
    input  logic              clk,
    input  logic              reset,
    fifo_up_buffer_if.slave   bus
);

    localparam int unsigned DEPTH = 1 << ADDR_SIZE;
    localparam int unsigned CNT_W = ADDR_SIZE + 1;

    // Storage and pointers.
    logic [DATA_SIZE-1:0] mem_q [DEPTH];
    logic [DATA_SIZE-1:0] mem_d [DEPTH];
    logic [ADDR_SIZE-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_SIZE-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0]     count_q,  count_d;

    // Read port and status registers.
    logic [DATA_SIZE-1:0] data_out_q, data_out_d;
    logic                 valid_out_q, valid_out_d;
    logic                 error_q, error_d;

    // Combinational decodes of the registered occupancy.
    logic full_c;
    logic empty_c;
    logic almost_full_c;
    logic almost_empty_c;

    // Request qualification.
    logic push_acc_c;
    logic pop_acc_c;
    logic overflow_c;
    logic underflow_c;

    // Status flags depend only on the registered count.
    always_comb begin
        full_c         = (count_q == CNT_W'(DEPTH));
        empty_c        = (count_q == CNT_W'(0));
        almost_full_c  = (count_q >= CNT_W'(AF_THRESHOLD));
        almost_empty_c = (count_q <= CNT_W'(AE_THRESHOLD));
    end

    // Accept/reject decisions; a pop on a full FIFO makes room for a push.
    always_comb begin
        pop_acc_c   = bus.pop && !empty_c;
        push_acc_c  = bus.push && (!full_c || pop_acc_c);
        overflow_c  = bus.push && full_c && !pop_acc_c;
        underflow_c = bus.pop && empty_c;
    end

    // Next-state computation for pointers, occupancy, read port and error.
    always_comb begin
        mem_d       = mem_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        data_out_d  = data_out_q;
        valid_out_d = 1'b0;
        error_d     = error_q;

        if (push_acc_c) begin
            mem_d[wr_ptr_q] = bus.data_in;
            wr_ptr_d        = wr_ptr_q + ADDR_SIZE'(1);
        end

        if (pop_acc_c) begin
            data_out_d  = mem_q[rd_ptr_q];
            rd_ptr_d    = rd_ptr_q + ADDR_SIZE'(1);
            valid_out_d = 1'b1;
        end

        case ({push_acc_c, pop_acc_c})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (overflow_c || underflow_c) begin
            error_d = 1'b1;
        end
    end

    // Control registers with synchronous reset; reset wins over push/pop.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            data_out_q  <= '0;
            valid_out_q <= 1'b0;
            error_q     <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            data_out_q  <= data_out_d;
            valid_out_q <= valid_out_d;
            error_q     <= error_d;
        end
    end

    // Storage array is not cleared by reset; writes are blocked while in reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            mem_q <= mem_d;
        end
    end

    // Drive the interface.
    assign bus.data_out     = data_out_q;
    assign bus.valid_out    = valid_out_q;
    assign bus.full         = full_c;
    assign bus.empty        = empty_c;
    assign bus.almost_full  = almost_full_c;
    assign bus.almost_empty = almost_empty_c;
    assign bus.count        = count_q;
    assign bus.error        = error_q;

endmodule
